// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

  // Arbiter sequencing: capture a command, let the RAM sample it, return the ack.
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

  // Requesting port; also the encoding of the round-robin history bit.
  typedef enum logic {PORT_I, PORT_D} port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two CPU request ports and the single-port RAM command bus.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
);
  // Instruction-fetch port (read only)
  logic                    i_req;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic                    i_ack;
  logic [DATA_WIDTH-1:0]   i_rdata;
  // Data port
  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_ack;
  logic [DATA_WIDTH-1:0]   d_rdata;
  // RAM command bus
  logic                    ram_en;
  logic [DATA_WIDTH/8-1:0] ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata, ram_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata, ram_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the
// instruction-fetch and data ports. One access every three cycles; all
// command and ack outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t            state_q;
  port_t                 last_gnt_q;
  port_t                 pick;
  logic                  ram_en_q;
  logic [BE_WIDTH-1:0]   ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  i_ack_q;
  logic                  d_ack_q;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    pick = PORT_I;
    if (bus.i_req && bus.d_req) begin
      pick = (last_gnt_q == PORT_D) ? PORT_I : PORT_D;
    end else if (bus.d_req) begin
      pick = PORT_D;
    end
  end

  // Access sequencer with registered RAM command and ack outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_D;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            state_q    <= ISSUE;
            last_gnt_q <= pick;
            ram_en_q   <= 1'b1;
            if (pick == PORT_I) begin
              ram_we_q   <= '0;
              ram_addr_q <= bus.i_addr;
            end else begin
              ram_we_q    <= bus.d_we ? bus.d_be : '0;
              ram_addr_q  <= bus.d_addr;
              ram_wdata_q <= bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          // RAM samples the command at the end of this cycle.
          state_q  <= RESP;
          ram_en_q <= 1'b0;
          ram_we_q <= '0;
          if (last_gnt_q == PORT_I) begin
            i_ack_q <= 1'b1;
          end else begin
            d_ack_q <= 1'b1;
          end
        end
        RESP: begin
          // Requests are not sampled here: they still belong to the access just served.
          state_q <= IDLE;
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  // Read data comes straight from the RAM output register; meaningful only with ack.
  assign bus.i_rdata   = bus.ram_rdata;
  assign bus.d_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level scheduling and memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Board RAM stand-in: 256 words, registered read, byte writes, preload port.
  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [7:0]  ram_idx;
  assign ram_idx = 8'(bus.ram_addr);

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b]) mem[ram_idx][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      end
      bus.ram_rdata <= mem[ram_idx];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  port_t       m_last;
  int          next_free, exp_en_cyc, exp_ack_cyc, pw_cyc;
  port_t       exp_port;
  logic [13:0] exp_addr;
  logic [3:0]  exp_we;
  logic [31:0] exp_wdata, exp_rdata;
  logic        exp_is_read;
  logic        pw_valid;
  logic [7:0]  pw_addr;
  logic [3:0]  pw_be;
  logic [31:0] pw_data;

  // Requester state
  txn_t  iq[$], dq[$];
  logic  i_busy, d_busy, i_done, d_done;
  int    scramble_mode;
  int    i_raise_cyc, i_lat;
  int    i_ack_total, d_ack_total;
  logic [31:0] last_i_rdata, last_d_rdata;
  port_t ack_order[$];
  int    ack_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(logic we, logic [13:0] a, logic [3:0] be, logic [31:0] wd, int gap);
    txn_t t;
    t.we = we; t.addr = a; t.be = be; t.wdata = wd; t.gap = gap;
    return t;
  endfunction

  task automatic model_reset();
    m_last = PORT_D; next_free = 0; exp_en_cyc = -10; exp_ack_cyc = -10; pw_valid = 1'b0;
  endtask

  // One access at a time; a free arbiter grants on the edge a request is seen,
  // the RAM acts one edge later and the arbiter is free again three edges on.
  task automatic model_edge();
    port_t p;
    if (reset === 1'b1 && cyc >= next_free && (bus.i_req || bus.d_req)) begin
      if (bus.i_req && bus.d_req) p = (m_last == PORT_D) ? PORT_I : PORT_D;
      else p = bus.i_req ? PORT_I : PORT_D;
      m_last = p; exp_port = p;
      exp_en_cyc = cyc; exp_ack_cyc = cyc + 1; next_free = cyc + 3;
      if (p == PORT_I) begin
        exp_addr = bus.i_addr; exp_we = 4'h0; exp_is_read = 1'b1;
        exp_rdata = ref_mem[8'(bus.i_addr)];
      end else begin
        exp_addr = bus.d_addr; exp_we = bus.d_we ? bus.d_be : 4'h0;
        exp_wdata = bus.d_wdata; exp_is_read = !bus.d_we;
        exp_rdata = ref_mem[8'(bus.d_addr)];
        pw_valid = bus.d_we; pw_cyc = cyc + 1;
        pw_addr = 8'(bus.d_addr); pw_be = bus.d_be; pw_data = bus.d_wdata;
      end
    end
  endtask

  task automatic drive();
    txn_t t;
    if (scramble_mode != 0 && exp_en_cyc == cyc) begin
      if (exp_port == PORT_D) begin
        if (scramble_mode == 1) bus.d_addr = bus.d_addr + 14'd1;
        else if ($urandom_range(1) == 1) begin
          bus.d_addr = 14'($urandom_range(255)); bus.d_wdata = $urandom;
          bus.d_be = 4'($urandom_range(15)); bus.d_we = 1'($urandom_range(1));
        end
      end else if (scramble_mode == 2) begin
        bus.i_addr = 14'($urandom_range(255));
      end
    end
    if (i_done) begin i_done = 1'b0; i_busy = 1'b0; bus.i_req = 1'b0; end
    if (!i_busy && iq.size() > 0) begin
      if (iq[0].gap > 0) iq[0].gap = iq[0].gap - 1;
      else begin
        t = iq.pop_front();
        bus.i_req = 1'b1; bus.i_addr = t.addr; i_busy = 1'b1; i_raise_cyc = cyc;
      end
    end
    if (exp_ack_cyc == cyc && exp_port == PORT_I) i_done = 1'b1;
    if (d_done) begin d_done = 1'b0; d_busy = 1'b0; bus.d_req = 1'b0; end
    if (!d_busy && dq.size() > 0) begin
      if (dq[0].gap > 0) dq[0].gap = dq[0].gap - 1;
      else begin
        t = dq.pop_front();
        bus.d_req = 1'b1; bus.d_we = t.we; bus.d_addr = t.addr;
        bus.d_be = t.be; bus.d_wdata = t.wdata; d_busy = 1'b1;
      end
    end
    if (exp_ack_cyc == cyc && exp_port == PORT_D) d_done = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (pw_valid && pw_cyc == cyc) begin
      for (int b = 0; b < 4; b++)
        if (pw_be[b]) ref_mem[pw_addr][b*8 +: 8] = pw_data[b*8 +: 8];
      pw_valid = 1'b0;
    end
    chk("i_ack", 32'(bus.i_ack), 32'(exp_ack_cyc == cyc && exp_port == PORT_I));
    chk("d_ack", 32'(bus.d_ack), 32'(exp_ack_cyc == cyc && exp_port == PORT_D));
    chk("ram_en", 32'(bus.ram_en), 32'(exp_en_cyc == cyc));
    if (exp_en_cyc == cyc) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
      chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
      if (exp_port == PORT_D) chk("ram_wdata", bus.ram_wdata, exp_wdata);
    end
    if (exp_ack_cyc == cyc && exp_is_read) begin
      if (exp_port == PORT_I) chk("i_rdata", bus.i_rdata, exp_rdata);
      else chk("d_rdata", bus.d_rdata, exp_rdata);
    end
    if (bus.i_ack === 1'b1) begin
      i_ack_total++; last_i_rdata = bus.i_rdata; i_lat = cyc - i_raise_cyc;
      ack_order.push_back(PORT_I); ack_cyc.push_back(cyc);
    end
    if (bus.d_ack === 1'b1) begin
      d_ack_total++; last_d_rdata = bus.d_rdata;
      ack_order.push_back(PORT_D); ack_cyc.push_back(cyc);
    end
    drive();
  endtask

  task automatic run_until_quiet(input int max);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_busy || d_busy) && n < max) begin
      step();
      n++;
    end
    chk("quiet_within_budget", 32'(n < max), 32'd1);
  endtask

  initial begin
    int base, d_base, n;
    logic [31:0] v;
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_be = '0; bus.d_wdata = '0;
    i_busy = 0; d_busy = 0; i_done = 0; d_done = 0; scramble_mode = 0;
    i_raise_cyc = 0; i_lat = 0; i_ack_total = 0; d_ack_total = 0;
    model_reset();
    #2 reset = 1'b0;

    // Preload RAM and reference while held in reset; outputs must stay at reset values.
    for (int a = 0; a < 256; a++) begin
      v = $urandom;
      case (a)
        'h10: v = 32'hDEADBEEF;
        'h20: v = 32'h11223344;
        'h30: v = 32'h55AA55AA;
        'h40: v = 32'hA0A0A0A0;
        'h41: v = 32'hB1B1B1B1;
        default: ;
      endcase
      ref_mem[a] = v;
      pl_en = 1'b1; pl_addr = 8'(a); pl_data = v;
      step();
    end
    pl_en = 1'b0;
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    reset = 1'b1;
    step();

    // First tie after reset goes to I, D follows three cycles later.
    base = ack_order.size();
    iq.push_back(mk(0, 14'h10, 4'h0, 32'h0, 0));
    dq.push_back(mk(0, 14'h50, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("tie_first_I", 32'(ack_order[base]), 32'(PORT_I));
    chk("tie_second_D", 32'(ack_order[base+1]), 32'(PORT_D));
    chk("tie_ack_spacing", 32'(ack_cyc[base+1] - ack_cyc[base]), 32'd3);

    // I-only read.
    d_base = d_ack_total;
    iq.push_back(mk(0, 14'h10, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("i_only_rdata", last_i_rdata, 32'hDEADBEEF);
    chk("i_only_latency", 32'(i_lat), 32'd2);
    chk("i_only_no_d_ack", 32'(d_ack_total - d_base), 32'd0);

    // Single-byte write then read back.
    dq.push_back(mk(1, 14'h20, 4'b0010, 32'h0000AB00, 0));
    dq.push_back(mk(0, 14'h20, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("byte_write_readback", last_d_rdata, 32'h1122AB44);

    // Sustained contention: 6 accesses per port, strictly alternating.
    base = ack_order.size();
    for (int k = 0; k < 6; k++) begin
      iq.push_back(mk(0, 14'($urandom_range(255)), 4'h0, 32'h0, 0));
      dq.push_back(mk(0, 14'($urandom_range(255)), 4'h0, 32'h0, 0));
    end
    run_until_quiet(100);
    chk("contention_ack_count", 32'(ack_order.size() - base), 32'd12);
    for (int k = 0; k < 12 && base + k < ack_order.size(); k++) begin
      chk("contention_order", 32'(ack_order[base+k]), (k % 2 == 0) ? 32'(PORT_I) : 32'(PORT_D));
      if (k > 0) chk("contention_spacing", 32'(ack_cyc[base+k] - ack_cyc[base+k-1]), 32'd3);
    end

    // Reset during ISSUE drops the write and restores the tie history.
    dq.push_back(mk(1, 14'h30, 4'hF, 32'hCAFEF00D, 0));
    n = 0;
    while (!(exp_en_cyc == cyc && exp_port == PORT_D) && n < 20) begin
      step();
      n++;
    end
    chk("rst_grant_seen", 32'(n < 20), 32'd1);
    reset = 1'b0;
    model_reset();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    i_busy = 0; d_busy = 0; i_done = 0; d_done = 0;
    base = ack_order.size();
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    step();
    chk("rst_no_ack", 32'(ack_order.size() - base), 32'd0);
    chk("rst_mem_unchanged", mem[8'h30], 32'h55AA55AA);
    iq.push_back(mk(0, 14'h30, 4'h0, 32'h0, 0));
    dq.push_back(mk(0, 14'h30, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("rst_tie_first_I", 32'(ack_order[base]), 32'(PORT_I));
    chk("rst_read_old", last_d_rdata, 32'h55AA55AA);

    // Address change during ISSUE must not redirect the access.
    scramble_mode = 1;
    dq.push_back(mk(1, 14'h40, 4'hF, 32'h13579BDF, 0));
    run_until_quiet(40);
    scramble_mode = 0;
    dq.push_back(mk(0, 14'h40, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("stable_hit_0x40", last_d_rdata, 32'h13579BDF);
    dq.push_back(mk(0, 14'h41, 4'h0, 32'h0, 0));
    run_until_quiet(40);
    chk("stable_0x41_untouched", last_d_rdata, 32'hB1B1B1B1);

    // Randomized mixed traffic with gaps and attribute churn after capture.
    scramble_mode = 2;
    for (int k = 0; k < 60; k++) begin
      iq.push_back(mk(0, 14'($urandom_range(255)), 4'h0, 32'h0, int'($urandom_range(3))));
      dq.push_back(mk(1'($urandom_range(1)), 14'($urandom_range(255)), 4'($urandom_range(15)),
                      $urandom, int'($urandom_range(3))));
    end
    run_until_quiet(3000);
    scramble_mode = 0;
    for (int k = 0; k < 3; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
